pkt_record_loader: RTL and testbench
====================================

# pkt_record_loader

Sequencer that assembles a packed configuration record from a 64-bit word stream. The record holds a three-entry 64-bit array plus two 32-bit integer fields, `r` and `th`. The block sits between a 64-bit valid/ready configuration source and the datapath that consumes the packed record. It stages words, commits a complete record atomically, holds it under an output valid/ready handshake, and discards malformed records with an error pulse.

## Interface
- No parameters; record layout is fixed at 4 words.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  source has a word.
- `in_ready`  out  1  block accepts a word this cycle.
- `in_data`  in  64  word payload.
- `in_last`  in  1  marks the final word of a record.
- `out_valid`  out  1  committed record available.
- `out_ready`  in  1  consumer takes the record.
- `out_a`  out  192  committed array, {a[2], a[1], a[0]}.
- `out_r`  out  32  committed `r` field.
- `out_th`  out  32  committed `th` field.
- `err`  out  1  one-cycle pulse: malformed record dropped.
- `rec_count`  out  8  number of records delivered to the consumer, wraps.

## Operation
- States: LOAD, with word index `idx` 0..3, and HOLD.
- Reset (`rst`=1 at an edge):
  - State goes to LOAD with `idx`=0.
  - `out_valid`=0, `err`=0, `rec_count`=0.
  - `out_a`, `out_r`, `out_th` all zero; staging registers zero.
- `in_ready` = 1 in LOAD, 0 in HOLD; combinational from state only.
- Transfer = `in_valid` & `in_ready`. Word placement by `idx`:
  - idx 0 → staging a[2] (most significant 64 bits of `out_a`).
  - idx 1 → a[1].
  - idx 2 → a[0].
  - idx 3 → `r` = `in_data[63:32]`, `th` = `in_data[31:0]`.
- Transfer at idx 0..2 with `in_last`=0: store the word, `idx`++.
- Transfer at idx 3 with `in_last`=1 (commit):
  - Staging a[2..0] plus the current word are copied to `out_a`/`out_r`/`out_th` in the same edge.
  - State goes to HOLD, `idx`=0.
- Transfer at idx 0..2 with `in_last`=1 (early last):
  - Record dropped; `err`=1 next cycle; `idx`=0.
  - Output registers and `rec_count` are unchanged.
- Transfer at idx 3 with `in_last`=0 (missing last):
  - Same as early last: drop, `err` pulse, `idx`=0.
  - The next word is treated as idx 0 of a new record.
- HOLD:
  - `out_valid`=1; `out_a`/`out_r`/`out_th` are stable.
  - On `out_ready`=1: `rec_count`++ (mod 256), state goes to LOAD.
  - `out_valid` deasserts the next cycle.
- Output registers change only on commit or reset; a partial load never disturbs the committed record.
- `in_valid` low in LOAD: hold `idx`; no timeout.
- `out_ready` in LOAD is ignored.

## Timing
- Commit latency: `out_valid` rises the cycle after the idx-3 transfer.
- Release: `in_ready` rises the cycle after the `out_valid` & `out_ready` handshake (one bubble; no bypass).
- Minimum period per record is 5 cycles: 4 transfers plus 1 HOLD cycle with `out_ready` held high.
- `err` is asserted exactly one cycle, the cycle after the offending transfer.
- No transfer can coincide with HOLD, so commit and output handshake never overlap.
- `rst` mid-record or mid-HOLD:
  - Staged words are discarded.
  - Any pending `out_valid` is cleared without counting.
  - All outputs return to reset values at that edge.

## Test plan
- Reset then stream 64'h9, 64'h12, 64'h21, {32'd1, 32'd170} (last on 4th), `out_ready`=1:
  - `out_valid` asserts 1 cycle after the 4th transfer.
  - `out_a`=192'h0000000000000009_0000000000000012_0000000000000021.
  - `out_r`=1, `out_th`=170; `rec_count`=1 after handshake.
  - `in_ready` returns high one cycle later.
- Backpressure: commit the same record with `out_ready`=0 for 6 cycles:
  - `out_valid` and outputs stay constant; `in_ready`=0 throughout.
  - `in_valid` stays high the whole time with no word accepted.
- Early last: 2 words with `in_last` on the 2nd:
  - `err` pulses one cycle; outputs still hold the prior record.
  - A following well-formed record (64'h1, 64'h2, 64'h3, 64'hAA) commits correctly.
- Missing last: 5 words, `in_last` only on the 5th:
  - `err` after the 4th transfer; the 5th word is staged as idx 0.
  - Three more words, last on the third, then commit a record with a[2] = the 5th word.
- Reset mid-operation:
  - Assert `rst` after 2 transfers: `idx`=0, `out_valid`=0, outputs zero.
  - Assert `rst` during HOLD: `out_valid` drops and `rec_count` stays 0.
- Wrap: deliver 256 records back-to-back with `out_ready`=1:
  - `rec_count` returns to 0.
  - Each record takes exactly 5 cycles.

Source files
------------

// File: rtl/pkt_record_loader_if.sv
// Word-stream input and committed-record output of pkt_record_loader.
// master drives the stream and the consumer ready; slave is the loader itself.
interface pkt_record_loader_if;
  localparam int unsigned WORD_W  = 64;
  localparam int unsigned ARR_W   = 192;
  localparam int unsigned FIELD_W = 32;

  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ARR_W-1:0]   out_a;
  logic [FIELD_W-1:0] out_r;
  logic [FIELD_W-1:0] out_th;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_a, out_r, out_th
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_a, out_r, out_th
  );
endinterface

// File: rtl/pkt_record_loader.sv
// Stages a 4-word record (a[2], a[1], a[0], {r, th}) and commits it atomically;
// the committed record is held under valid/ready, malformed records pulse err.
module pkt_record_loader (
  input  logic                      clk,
  input  logic                      rst,
  pkt_record_loader_if.slave        bus,
  output logic                      err,
  output logic [7:0]                rec_count
);
  localparam int unsigned WORD_W  = 64;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned FIELD_W = 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(3);

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic              xfer;
  logic              stage_en;
  logic              commit;
  logic              drop;
  logic              deliver;
  logic [WORD_W-1:0] stage_a2;
  logic [WORD_W-1:0] stage_a1;
  logic [WORD_W-1:0] stage_a0;

  // State register: FSM state plus word index within the record.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state: classify each transfer as stage, commit or drop.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    xfer      = 1'b0;
    stage_en  = 1'b0;
    commit    = 1'b0;
    drop      = 1'b0;
    deliver   = 1'b0;
    case (state)
      LOAD: begin
        xfer = bus.in_valid;
        if (xfer) begin
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
            if (bus.in_last) begin
              commit    = 1'b1;
              state_nxt = HOLD;
            end else begin
              drop = 1'b1;
            end
          end else if (bus.in_last) begin
            drop    = 1'b1;
            idx_nxt = '0;
          end else begin
            stage_en = 1'b1;
            idx_nxt  = idx + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          deliver   = 1'b1;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Output decode: handshake flags are pure functions of the registered state.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.in_ready  = (state == LOAD);
    bus.out_valid = (state == HOLD);
  end

  // Datapath: staging, committed record, error pulse and delivery counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_a2   <= '0;
      stage_a1   <= '0;
      stage_a0   <= '0;
      bus.out_a  <= '0;
      bus.out_r  <= '0;
      bus.out_th <= '0;
      err        <= 1'b0;
      rec_count  <= '0;
    end else begin
      err <= drop;
      if (stage_en) begin
        case (idx)
          IDX_W'(0): stage_a2 <= bus.in_data;
          IDX_W'(1): stage_a1 <= bus.in_data;
          IDX_W'(2): stage_a0 <= bus.in_data;
          default:   ;
        endcase
      end
      // The final word bypasses staging so the whole record lands in one edge.
      if (commit) begin
        bus.out_a  <= {stage_a2, stage_a1, stage_a0};
        bus.out_r  <= bus.in_data[WORD_W-1:FIELD_W];
        bus.out_th <= bus.in_data[FIELD_W-1:0];
      end
      if (deliver) begin
        rec_count <= rec_count + 8'(1);
      end
    end
  end
endmodule

// File: tb/tb_pkt_record_loader.sv
// Directed bench for pkt_record_loader: commit, backpressure, malformed
// records, mid-operation reset and rec_count wrap with 5-cycle throughput.
module tb_pkt_record_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic       err;
  logic [7:0] rec_count;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         t0;

  localparam logic [191:0] REC1_A = 192'h0000000000000009_0000000000000012_0000000000000021;

  pkt_record_loader_if bus();

  pkt_record_loader dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err       (err),
    .rec_count (rec_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d, input logic last);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_timeout: in_ready observed %b expected 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_rec(input logic [63:0] a2, input logic [63:0] a1,
                          input logic [63:0] a0, input logic [31:0] r,
                          input logic [31:0] th);
    send_word(a2, 1'b0);
    send_word(a1, 1'b0);
    send_word(a0, 1'b0);
    send_word({r, th}, 1'b1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 192'(bus.out_valid), 192'(0));
    chk("rst_in_ready",  192'(bus.in_ready),  192'(1));
    chk("rst_out_a",     bus.out_a,           192'(0));
    chk("rst_out_r",     192'(bus.out_r),     192'(0));
    chk("rst_out_th",    192'(bus.out_th),    192'(0));
    chk("rst_err",       192'(err),           192'(0));
    chk("rst_rec_count", 192'(rec_count),     192'(0));

    // Basic record with consumer ready
    bus.out_ready = 1'b1;
    send_word(64'h9,  1'b0);
    send_word(64'h12, 1'b0);
    send_word(64'h21, 1'b0);
    chk("basic_no_early_valid", 192'(bus.out_valid), 192'(0));
    send_word({32'd1, 32'd170}, 1'b1);
    chk("basic_valid",    192'(bus.out_valid), 192'(1));
    chk("basic_in_ready", 192'(bus.in_ready),  192'(0));
    chk("basic_out_a",    bus.out_a,           REC1_A);
    chk("basic_out_r",    192'(bus.out_r),     192'(1));
    chk("basic_out_th",   192'(bus.out_th),    192'(170));
    step();
    chk("basic_valid_drop", 192'(bus.out_valid), 192'(0));
    chk("basic_release",    192'(bus.in_ready),  192'(1));
    chk("basic_rec_count",  192'(rec_count),     192'(1));

    // Backpressure: consumer stalls 6 cycles while the source keeps offering
    bus.out_ready = 1'b0;
    send_rec(64'h9, 64'h12, 64'h21, 32'd1, 32'd170);
    chk("bp_valid", 192'(bus.out_valid), 192'(1));
    bus.in_valid = 1'b1;
    bus.in_data  = 64'hDEAD;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_hold_valid", 192'(bus.out_valid), 192'(1));
      chk("bp_in_ready",   192'(bus.in_ready),  192'(0));
      chk("bp_out_a",      bus.out_a,           REC1_A);
      chk("bp_rec_count",  192'(rec_count),     192'(1));
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_valid", 192'(bus.out_valid), 192'(0));
    chk("bp_rec_count_inc", 192'(rec_count),     192'(2));

    // Early last: second word flagged last
    send_word(64'h5, 1'b0);
    send_word(64'h6, 1'b1);
    chk("early_err",       192'(err),           192'(1));
    chk("early_no_valid",  192'(bus.out_valid), 192'(0));
    chk("early_out_a",     bus.out_a,           REC1_A);
    chk("early_out_th",    192'(bus.out_th),    192'(170));
    chk("early_rec_count", 192'(rec_count),     192'(2));
    step();
    chk("early_err_pulse", 192'(err), 192'(0));
    send_rec(64'h1, 64'h2, 64'h3, 32'h0, 32'hAA);
    chk("early_next_valid", 192'(bus.out_valid), 192'(1));
    chk("early_next_out_a", bus.out_a,
        192'h0000000000000001_0000000000000002_0000000000000003);
    chk("early_next_out_r",  192'(bus.out_r),  192'(0));
    chk("early_next_out_th", 192'(bus.out_th), 192'(32'hAA));
    step();
    chk("early_next_rec_count", 192'(rec_count), 192'(3));

    // Missing last: 4th word lacks last, 5th word restarts the record
    send_word(64'h11, 1'b0);
    send_word(64'h22, 1'b0);
    send_word(64'h33, 1'b0);
    send_word(64'h44, 1'b0);
    chk("miss_err",      192'(err),           192'(1));
    chk("miss_no_valid", 192'(bus.out_valid), 192'(0));
    send_word(64'h55, 1'b0);
    chk("miss_err_pulse", 192'(err), 192'(0));
    send_word(64'h66, 1'b0);
    send_word(64'h77, 1'b0);
    send_word({32'hCAFE0001, 32'h0000BEEF}, 1'b1);
    chk("miss_valid", 192'(bus.out_valid), 192'(1));
    chk("miss_out_a", bus.out_a,
        192'h0000000000000055_0000000000000066_0000000000000077);
    chk("miss_out_r",  192'(bus.out_r),  192'(32'hCAFE0001));
    chk("miss_out_th", 192'(bus.out_th), 192'(32'h0000BEEF));
    step();
    chk("miss_rec_count", 192'(rec_count), 192'(4));

    // Reset after two staged words
    send_word(64'h101, 1'b0);
    send_word(64'h102, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid",     192'(bus.out_valid), 192'(0));
    chk("mid_rst_in_ready",  192'(bus.in_ready),  192'(1));
    chk("mid_rst_out_a",     bus.out_a,           192'(0));
    chk("mid_rst_out_r",     192'(bus.out_r),     192'(0));
    chk("mid_rst_out_th",    192'(bus.out_th),    192'(0));
    chk("mid_rst_rec_count", 192'(rec_count),     192'(0));

    // Fresh record after reset must start at idx 0; then reset during HOLD
    bus.out_ready = 1'b0;
    send_rec(64'h201, 64'h202, 64'h203, 32'd7, 32'd8);
    chk("post_rst_valid", 192'(bus.out_valid), 192'(1));
    chk("post_rst_out_a", bus.out_a,
        192'h0000000000000201_0000000000000202_0000000000000203);
    chk("post_rst_out_r", 192'(bus.out_r), 192'(7));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("hold_rst_valid",     192'(bus.out_valid), 192'(0));
    chk("hold_rst_rec_count", 192'(rec_count),     192'(0));
    chk("hold_rst_out_a",     bus.out_a,           192'(0));
    chk("hold_rst_out_th",    192'(bus.out_th),    192'(0));

    // 256 back-to-back records: counter wraps, 5 cycles per record
    bus.out_ready = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 256; k++) begin
      send_rec(64'(k), 64'(k) + 64'h1000, 64'(k) + 64'h2000, 32'(k), ~32'(k));
      if (k == 1) chk("wrap_rec_count_1", 192'(rec_count), 192'(1));
    end
    step();
    chk("wrap_rec_count", 192'(rec_count), 192'(0));
    chk("wrap_cycles",    192'(cyc - t0),  192'(1280));
    chk("wrap_last_out_a", bus.out_a,
        192'h00000000000000FF_00000000000010FF_00000000000020FF);
    chk("wrap_last_out_th", 192'(bus.out_th), 192'(32'hFFFFFF00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
